// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver state encoding, prefix codes and frame helpers
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_FRAME_LEN = 11;

    // Odd parity over data plus parity bit, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - pin synchroniser with ps2_clk debounce and falling-edge strobe
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic clk_level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_ff;
    logic [1:0]    data_ff;
    logic [CW-1:0] cnt;
    logic          change;

    // The FILTER_LEN-th consecutive sample that disagrees with the held level flips it.
    assign change    = (cnt == CW'(FILTER_LEN - 1)) && (clk_ff[1] != clk_level);
    assign data_sync = data_ff[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_ff    <= 2'b11;
            data_ff   <= 2'b11;
            cnt       <= '0;
            clk_level <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk};
            data_ff <= {data_ff[0], ps2_data};
            fall    <= change && clk_level;
            if (clk_ff[1] == clk_level || change) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (change) begin
                clk_level <= clk_ff[1];
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 frame receiver delivering make codes with break/extended filtering
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DONE_HOLD      = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tasta,
    output logic       done,
    output logic       ext,
    output logic       frame_err
);

    localparam int DATA_BITS = PS2_FRAME_LEN - 3;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW        = $clog2(DONE_HOLD + 1);

    logic          data_sync;
    logic          clk_level;
    logic          fall_raw;
    logic          fall;
    ps2_state_t    state;
    ps2_state_t    state_n;
    logic          shift_en;
    logic          par_en;
    logic          stop_en;
    logic          abort;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          byte_vld;
    logic [7:0]    byte_q;
    logic          break_pend;
    logic          ext_pend;
    logic          deliver;
    logic [HW-1:0] hold_cnt;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(data_sync),
        .clk_level(clk_level),
        .fall     (fall_raw)
    );

    assign fall = fall_raw & ~clk_level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A fall in the same clock as the timeout wins, so the abort is only taken without one.
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        abort    = 1'b0;
        if (state != ST_IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = ST_IDLE;
            abort   = 1'b1;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!data_sync) state_n = ST_DATA;
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_en  = 1'b1;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    stop_en = 1'b1;
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            sh        <= '0;
            par       <= 1'b0;
            tmo_cnt   <= '0;
            byte_vld  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort | (stop_en & ~frame_ok(sh, par, data_sync));
            byte_vld  <= stop_en & frame_ok(sh, par, data_sync);
            if (stop_en) byte_q <= sh;
            if (fall || state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) sh <= {data_sync, sh[7:1]};
            if (par_en) par <= data_sync;
        end
    end

    assign deliver = byte_vld && !break_pend && byte_q != PS2_EXT && byte_q != PS2_BREAK;
    assign done    = (hold_cnt != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            tasta      <= '0;
            ext        <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            if (byte_vld) begin
                if (byte_q == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (byte_q == PS2_BREAK) begin
                    break_pend <= 1'b1;
                end else if (break_pend) begin
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                end else begin
                    tasta    <= byte_q;
                    ext      <= ext_pend;
                    ext_pend <= 1'b0;
                end
            end
            if (deliver) begin
                hold_cnt <= HW'(DONE_HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed plus randomized frames checked against a scancode-level model
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int DONE_HOLD      = 1;
    // Pin fall to done: 2 synchroniser stages, FILTER_LEN samples, byte register, done register.
    localparam int LATENCY        = 2 + FILTER_LEN + 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] tasta;
    logic       done;
    logic       ext;
    logic       frame_err;

    int compared   = 0;
    int mismatched = 0;

    int   cyc           = 0;
    int   done_rises    = 0;
    int   done_cycles   = 0;
    int   err_cycles    = 0;
    int   last_rise_cyc = 0;
    logic done_d        = 1'b0;
    int   stop_cyc      = 0;

    logic [7:0] m_tasta = 8'h00;
    logic       m_ext   = 1'b0;
    logic       m_brk   = 1'b0;
    logic       m_extp  = 1'b0;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .DONE_HOLD     (DONE_HOLD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .tasta    (tasta),
        .done     (done),
        .ext      (ext),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done) done_cycles <= done_cycles + 1;
        if (frame_err) err_cycles <= err_cycles + 1;
        if (done && !done_d) begin
            done_rises    <= done_rises + 1;
            last_rise_cyc <= cyc;
        end
        done_d <= done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic val, input int half, input bit glitch, input bit is_stop);
        @(negedge clock);
        ps2_data = val;
        if (glitch) begin
            repeat (10) @(negedge clock);
            ps2_clk = 1'b0;
            @(negedge clock);
            ps2_clk = 1'b1;
            repeat (half - 11) @(negedge clock);
        end else begin
            repeat (half) @(negedge clock);
        end
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        if (glitch) begin
            repeat (10) @(negedge clock);
            ps2_clk = 1'b1;
            @(negedge clock);
            ps2_clk = 1'b0;
            repeat (half - 11) @(negedge clock);
        end else begin
            repeat (half) @(negedge clock);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int half, input bit glitch);
        logic [10:0] bits;
        int d0, c0, e0;
        bit exp_err, exp_dl;
        d0 = done_rises;
        c0 = done_cycles;
        e0 = err_cycles;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], half, glitch, i == 10);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (20) @(negedge clock);

        exp_err = bad_par || bad_stop;
        exp_dl  = 1'b0;
        if (!exp_err) begin
            if (b == 8'hE0) m_extp = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (m_brk) begin
                m_brk  = 1'b0;
                m_extp = 1'b0;
            end else begin
                m_tasta = b;
                m_ext   = m_extp;
                m_extp  = 1'b0;
                exp_dl  = 1'b1;
            end
        end
        check({tag, ".done"}, done_rises - d0, 32'(exp_dl));
        check({tag, ".done_w"}, done_cycles - c0, exp_dl ? DONE_HOLD : 0);
        check({tag, ".err"}, err_cycles - e0, 32'(exp_err));
        check({tag, ".tasta"}, 32'(tasta), 32'(m_tasta));
        check({tag, ".ext"}, 32'(ext), 32'(m_ext));
        if (exp_dl) check({tag, ".lat"}, last_rise_cyc - stop_cyc, LATENCY);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".tasta"}, 32'(tasta), 32'h00);
        check({tag, ".done"}, 32'(done), 32'h0);
        check({tag, ".ext"}, 32'(ext), 32'h0);
        check({tag, ".ferr"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        int d0, e0, half;
        logic [7:0] b;
        bit bp, bs, gl;

        repeat (3) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (10) @(negedge clock);

        run_frame("space", 8'h29, 0, 0, 20, 0);
        run_frame("brk_f0", 8'hF0, 0, 0, 20, 0);
        run_frame("brk_1c", 8'h1C, 0, 0, 20, 0);
        run_frame("make_23", 8'h23, 0, 0, 20, 0);
        run_frame("ext_e0", 8'hE0, 0, 0, 20, 0);
        run_frame("ext_75", 8'h75, 0, 0, 20, 0);
        run_frame("plain_16", 8'h16, 0, 0, 20, 0);
        run_frame("badpar_1e", 8'h1E, 1, 0, 20, 0);
        run_frame("good_1e", 8'h1E, 0, 0, 20, 0);
        run_frame("badstop_5a", 8'h5A, 0, 1, 20, 0);
        run_frame("good_5a", 8'h5A, 0, 0, 20, 0);

        // Start plus four data bits, then the clock stays high past the timeout.
        d0 = done_rises;
        e0 = err_cycles;
        ps2_bit(1'b0, 20, 0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 20, 0, 0);
        repeat (TIMEOUT_CYCLES + 50) @(negedge clock);
        check("timeout.err", err_cycles - e0, 1);
        check("timeout.done", done_rises - d0, 0);
        ps2_data = 1'b1;
        run_frame("after_to_76", 8'h76, 0, 0, 20, 0);

        // Single-clock glitches while idle with data low must not start a frame.
        d0 = done_rises;
        e0 = err_cycles;
        ps2_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat (7) @(negedge clock);
            ps2_clk = 1'b0;
            @(negedge clock);
            ps2_clk = 1'b1;
        end
        repeat (TIMEOUT_CYCLES + 50) @(negedge clock);
        ps2_data = 1'b1;
        check("idle_glitch.err", err_cycles - e0, 0);
        check("idle_glitch.done", done_rises - d0, 0);

        // Pending E0 and a partial frame are both discarded by reset.
        run_frame("pre_rst_e0", 8'hE0, 0, 0, 20, 0);
        ps2_bit(1'b0, 20, 0, 0);
        ps2_bit(1'b1, 20, 0, 0);
        ps2_bit(1'b1, 20, 0, 0);
        @(negedge clock);
        ps2_clk = 1'b0;
        #3 reset = 1'b1;
        #1 check_reset_outputs("mid_rst");
        d0 = done_rises;
        e0 = err_cycles;
        repeat (4) @(negedge clock);
        check_reset_outputs("mid_rst_hold");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        reset = 1'b0;
        m_tasta = 8'h00;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_extp  = 1'b0;
        repeat (TIMEOUT_CYCLES + 20) @(negedge clock);
        check("post_rst.done", done_rises - d0, 0);
        check("post_rst.err", err_cycles - e0, 0);
        run_frame("glitch_4b", 8'h4B, 0, 0, 20, 1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            bp   = ($urandom_range(0, 7) == 0);
            bs   = ($urandom_range(0, 9) == 0);
            half = $urandom_range(8, 30);
            gl   = (half >= 14) && ($urandom_range(0, 1) == 1);
            run_frame($sformatf("rnd%0d", n), b, bp, bs, half, gl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver: deserialises device-clocked PS/2 frames into 8-bit scancodes.
- Delivers make codes on the `tasta`/`done` interface that the game FSM consumes.
- Filters break sequences (F0 xx) and tags extended (E0) keys.
- Sits between the board PS/2 pins and the game FSM, in the same system clock domain.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before ps2_clk is considered to have changed level.
- TIMEOUT_CYCLES, 50000: system clocks allowed between falling ps2_clk edges inside a frame before abort (1 ms at 50 MHz).
- DONE_HOLD, 1: number of clocks `done` stays high per delivered code.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- tasta  out  8  last delivered make code; holds until the next delivery.
- done  out  1  high for DONE_HOLD clocks when tasta updates.
- ext  out  1  1 if the delivered code was preceded by E0; valid with tasta.
- frame_err  out  1  one-clock pulse on parity error, bad stop bit or timeout.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - tasta=8'h00, done=0, ext=0, frame_err=0.
  - FSM=IDLE; break_pend=0, ext_pend=0; all counters 0; filtered clock level=1.
- Input conditioning:
  - 2-FF synchroniser on both pins.
  - ps2_clk filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - fall = filtered level 1->0, a one-clock strobe. Data is sampled from the synchronised ps2_data on the fall strobe.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1). 11 falls per frame.
- FSM states:
  - IDLE: on fall with data=0 -> DATA, bit_cnt=0. On fall with data=1, stay in IDLE with no error.
  - DATA: on each fall, shift into sh[7:0] from the MSB side (LSB arrives first); bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: on fall, store p. -> STOP.
  - STOP: on fall -> IDLE.
    - If stop=1 and ^{sh,p}==1, the byte is good.
    - Otherwise pulse frame_err, drop the byte, and leave pending flags unchanged.
- Timeout:
  - Counter clears on every fall and counts while the FSM is not IDLE.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE plus a frame_err pulse.
  - If timeout and fall occur in the same clock, the fall wins and the counter clears.
- Good byte handling, 1 clock after the STOP fall:
  - E0 -> ext_pend=1, no delivery.
  - F0 -> break_pend=1, no delivery.
  - Other byte with break_pend=1 -> clear break_pend and ext_pend, no delivery.
  - Other byte with break_pend=0 -> tasta=byte, ext=ext_pend, ext_pend=0, done high for DONE_HOLD clocks.
- Delivery latency: done rises exactly 2 clocks after the clock in which the stop-bit fall strobe is asserted.
- Simultaneous delivery: a new delivery while done is still high reloads tasta and restarts the hold count. No event is lost if frames are spaced by at least DONE_HOLD clocks.
- Reset mid-frame: the partial byte is discarded and no done is produced.

Decomposition:
- Package ps2_pkg holds:
  - state encoding: IDLE, DATA, PARITY, STOP (2 bits);
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0;
  - frame length 11.
- Sub-module ps2_sync_filter:
  - contains the synchroniser plus FILTER_LEN debounce;
  - outputs the sync'd data, the filtered clock level and the fall strobe.
- Top module holds the FSM, shift register, timeout, prefix flags and done stretcher.

Test Plan:
- Send a valid frame for 8'h29 (SPACE; data LSB-first 1,0,0,1,0,1,0,0; parity 0) -> done=1 for 1 clock, tasta=8'h29, ext=0, frame_err stays 0.
- Send F0 then 1C -> no done pulse; tasta keeps its prior value. A following 8'h23 -> done, tasta=8'h23.
- Send E0 then 75 -> done, tasta=8'h75, ext=1. A following 8'h16 -> ext=0.
- Send 8'h1E with the parity bit flipped -> frame_err pulses once, no done. A following valid 8'h1E is delivered.
- Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses and FSM returns to IDLE. A following 8'h76 is delivered correctly.
- Apply 1-clock glitches (< FILTER_LEN) on ps2_clk, and assert reset mid-frame -> no spurious bits, all outputs 0 during reset, next 8'h4B frame decodes.
